spi_slave_tx: RTL
=================

SPI_SLAVE_TX -- requirements
Module: spi_slave_tx

Interface
REQ-001 Parameter FRAME_BITS, default 16, SHALL set the sclk rising edges in one complete frame.
REQ-002 Parameter LEAD_BITS, default 3, SHALL set the zero bits sent before the data byte.
REQ-003 Parameter DATA_W, default 8, SHALL set the payload width; LEAD_BITS+DATA_W <= FRAME_BITS.
REQ-004 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 sclk  input  1  serial clock from the master; idle high; asynchronous to clk.
REQ-007 cs_n  input  1  chip select from the master, active-low; asynchronous to clk.
REQ-008 sdata  output  1  serial data to the master, MSB first.
REQ-009 sdata_oe  output  1  output enable for sdata; high only while a frame is active.
REQ-010 tx_data  input  DATA_W  payload byte offered by local logic.
REQ-011 tx_valid  input  1  tx_data is valid.
REQ-012 tx_ready  output  1  holding register empty; can accept a byte.
REQ-013 busy  output  1  frame in progress.
REQ-014 frame_done  output  1  one-clk pulse when a complete frame ends.
REQ-015 underrun  output  1  one-clk pulse when a frame starts with no fresh byte.

Function
REQ-016 sclk and cs_n SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized values against a third delayed flop (pin-to-detect latency 3 clk).
REQ-017 clk SHALL be at least 8x sclk; no other clock relationship is required.
REQ-018 The FSM SHALL have states IDLE, ACTIVE, FINISH.
REQ-019 IDLE -> ACTIVE on the detected cs_n falling edge; ACTIVE -> FINISH on the detected cs_n rising edge; FINISH -> IDLE after exactly one clk.
REQ-020 On IDLE -> ACTIVE, the shift register SHALL load {LEAD_BITS zeros, payload, zero padding to FRAME_BITS}; sdata SHALL present its MSB in the same cycle.
REQ-021 The payload SHALL be the holding register when full, which SHALL then empty; otherwise, the last transmitted payload (0 after reset), with underrun pulsed for one clk.
REQ-022 The first detected sclk falling edge in ACTIVE SHALL NOT shift; each later detected falling edge SHALL shift left one bit and fill with 0, so rising edge k carries frame bit k-1 (MSB = bit 0).
REQ-023 A rise counter SHALL count detected sclk rising edges in ACTIVE; it SHALL saturate at FRAME_BITS.
REQ-024 After FRAME_BITS shifts, sdata SHALL be 0 for any extra sclk edges.
REQ-025 frame_done SHALL pulse in FINISH only if the rise counter equals FRAME_BITS; if not, no pulse, and the payload still counts as used.
REQ-026 Holding register: tx_valid && tx_ready SHALL capture tx_data and clear tx_ready on the next clk; tx_ready SHALL rise the clk after the holding register empties.
REQ-027 A write in the same clk as frame start SHALL be captured into the holding register and SHALL NOT be used for the starting frame; underrun SHALL pulse if the register was empty before that clk.
REQ-028 tx_valid while tx_ready is low SHALL be ignored; the held byte SHALL NOT change.
REQ-029 busy and sdata_oe SHALL be high in ACTIVE and low in IDLE and FINISH; sdata SHALL be 0 when sdata_oe is low.
REQ-030 sclk edges seen in IDLE or FINISH SHALL be ignored.

Reset
REQ-031 Reset SHALL force state IDLE, sdata=0, sdata_oe=0, busy=0, frame_done=0, underrun=0, tx_ready=1, and clear the holding register, last payload, shift register, counters and synchronizers.
REQ-032 Reset during ACTIVE SHALL abort the frame immediately with no frame_done pulse; after release, the next frame SHALL start only on a new cs_n falling edge.

Verification
REQ-033 Write 0xA5, then run a 16-clock frame -> master samples 000_10100101_00000; frame_done=1 pulse; underrun=0; tx_ready high after load.
REQ-034 Run a frame with no write after reset -> payload 0x00, underrun pulses once; write 0x3C, then two frames -> 0x3C, then 0x3C again with underrun.
REQ-035 Raise cs_n after 6 rising edges -> no frame_done; FSM returns to IDLE; the next frame sends the next byte or repeats, as REQ-021.
REQ-036 Assert tx_valid on the same clk as detected cs_n fall with the holding register empty -> underrun pulses; byte is sent in the following frame.
REQ-037 Write 0x11, then write 0x22 while tx_ready=0 -> 0x22 is dropped; the frame sends 0x11.
REQ-038 Assert n_rst mid-frame -> all outputs at reset values within the same clk; no frame_done pulse.

Source files
------------

// File: rtl/spi_slave_tx_if.sv
// spi_slave_tx_if: SPI serial pins plus the local holding-register handshake and status.
interface spi_slave_tx_if #(parameter int DATA_W = 8);
  logic              sclk;
  logic              cs_n;
  logic              sdata;
  logic              sdata_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              frame_done;
  logic              underrun;
  modport slave (input sclk, cs_n, tx_data, tx_valid,
                 output sdata, sdata_oe, tx_ready, busy, frame_done, underrun);
  modport master (output sclk, cs_n, tx_data, tx_valid,
                  input sdata, sdata_oe, tx_ready, busy, frame_done, underrun);
endinterface

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI slave transmitter sending {LEAD_BITS zeros, payload, zero pad} per cs_n frame,
// with a one-entry holding register fed from local logic.
module spi_slave_tx #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 3,
  parameter int DATA_W     = 8
) (
  input  logic clk,
  input  logic n_rst,
  spi_slave_tx_if.slave bus
);
  localparam int PAD = FRAME_BITS - LEAD_BITS - DATA_W;
  localparam int CW  = $clog2(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;
  state_t              state_q, state_d;
  logic [2:0]          sclk_q, sclk_d, cs_q, cs_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [DATA_W-1:0]   hold_q, hold_d, last_q, last_d, payload;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                full_q, full_d, skip_q, skip_d;
  logic                frame_done_q, frame_done_d, underrun_q, underrun_d;
  logic                sclk_rise, sclk_fall, cs_fall, cs_rise, active, start, wr;
  // Index 1 is the synchronized value, index 2 its one-clk-delayed copy.
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign active    = state_q == ACTIVE;
  assign start     = state_q == IDLE && cs_fall;
  assign wr        = bus.tx_valid && !full_q;
  always_comb begin
    sclk_d       = {sclk_q[1:0], bus.sclk};
    cs_d         = {cs_q[1:0], bus.cs_n};
    payload      = full_q ? hold_q : last_q;
    state_d      = start ? ACTIVE : active && cs_rise ? FINISH : state_q == FINISH ? IDLE : state_q;
    hold_d       = wr ? bus.tx_data : hold_q;
    full_d       = start && full_q ? 1'b0 : wr ? 1'b1 : full_q;
    last_d       = start ? payload : last_q;
    sh_d         = start ? {{(FRAME_BITS-DATA_W){1'b0}}, payload} << PAD
                 : active && sclk_fall && !skip_q ? sh_q << 1 : sh_q;
    skip_d       = start ? 1'b1 : active && sclk_fall ? 1'b0 : skip_q;
    cnt_d        = start ? '0 : active && sclk_rise && cnt_q != CW'(FRAME_BITS) ? cnt_q + 1'b1 : cnt_q;
    frame_done_d = active && cs_rise && cnt_q == CW'(FRAME_BITS);
    underrun_d   = start && !full_q;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      sclk_q       <= '0;
      cs_q         <= '0;
      sh_q         <= '0;
      hold_q       <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      skip_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_q       <= sclk_d;
      cs_q         <= cs_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      skip_q       <= skip_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end
  assign bus.busy       = active;
  assign bus.sdata_oe   = active;
  assign bus.sdata      = active & sh_q[FRAME_BITS-1];
  assign bus.tx_ready   = ~full_q;
  assign bus.frame_done = frame_done_q;
  assign bus.underrun   = underrun_q;
endmodule
